// File: rtl/uart_receiver_if.sv
// Byte-side handshake of the UART receiver: received byte with valid/ready
// plus the one-cycle error flags.
interface uart_receiver_if;
  logic [7:0] data;
  logic       data_valid;
  logic       data_ready;
  logic       framing_error;
  logic       overrun;

  // Receiver side drives the byte and flags, consumer returns ready.
  modport master (
    output data,
    output data_valid,
    output framing_error,
    output overrun,
    input  data_ready
  );

  modport slave (
    input  data,
    input  data_valid,
    input  framing_error,
    input  overrun,
    output data_ready
  );
endinterface

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 asynchronous serial receiver (LSB first, idle high).
// Bytes are presented behind a valid/ready handshake; framing errors and
// overruns are reported as single-cycle pulses.
module uart_receiver #(
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned CLOCK_RATE = 25_000_000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            uart_rx,
  uart_receiver_if.master rx_bus
);

  localparam int unsigned DIV  = CLOCK_RATE / BAUD_RATE;
  localparam int unsigned HALF = DIV / 2;
  localparam int unsigned CW   = $clog2(DIV);

  localparam logic [CW-1:0] CNT_BIT_END   = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_MID_START = CW'(HALF - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  logic          rx_meta;
  logic          rx_s;
  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    sreg;
  logic [7:0]    data_q;
  logic          valid_q;
  logic          framing_error_q;
  logic          overrun_q;

  logic          bit_end;
  logic          mid_start;
  logic          accept;

  assign rx_bus.data          = data_q;
  assign rx_bus.data_valid    = valid_q;
  assign rx_bus.framing_error = framing_error_q;
  assign rx_bus.overrun       = overrun_q;

  // Two-flop synchroniser bringing the idle-high line into the clk domain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_s    <= rx_meta;
    end
  end

  // Baud-counter compare points and handshake acceptance.
  always_comb begin
    bit_end   = (cnt == CNT_BIT_END);
    mid_start = (cnt == CNT_MID_START);
    accept    = valid_q & rx_bus.data_ready;
  end

  // Frame state machine, shift register, output holding register and flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= S_IDLE;
      cnt             <= '0;
      idx             <= '0;
      sreg            <= '0;
      data_q          <= '0;
      valid_q         <= 1'b0;
      framing_error_q <= 1'b0;
      overrun_q       <= 1'b0;
    end else begin
      framing_error_q <= 1'b0;
      overrun_q       <= 1'b0;
      // Accept clears valid first; a byte completing on the same edge
      // re-sets it below, so the accept wins and no overrun is raised.
      if (accept) begin
        valid_q <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          cnt <= '0;
          idx <= '0;
          if (!rx_s) begin
            state <= S_START;
          end
        end

        S_START: begin
          if (mid_start) begin
            cnt   <= '0;
            state <= rx_s ? S_IDLE : S_DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        S_DATA: begin
          if (bit_end) begin
            sreg <= {rx_s, sreg[7:1]};
            cnt  <= '0;
            if (idx == 3'd7) begin
              idx   <= '0;
              state <= S_STOP;
            end else begin
              idx <= idx + 3'd1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        S_STOP: begin
          if (bit_end) begin
            cnt <= '0;
            if (rx_s) begin
              state <= S_IDLE;
              if (!valid_q || accept) begin
                data_q  <= sreg;
                valid_q <= 1'b1;
              end else begin
                overrun_q <= 1'b1;
              end
            end else begin
              framing_error_q <= 1'b1;
              state           <= S_BREAK;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        S_BREAK: begin
          cnt <= '0;
          idx <= '0;
          if (rx_s) begin
            state <= S_IDLE;
          end
        end

        default: begin
          state <= S_IDLE;
          cnt   <= '0;
          idx   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed and randomized checks of uart_receiver at 16 clocks per bit.
module tb_uart_receiver;

  localparam int CLOCK_RATE = 16;
  localparam int BAUD_RATE  = 1;
  localparam int DIV        = CLOCK_RATE / BAUD_RATE;
  localparam int HALF       = DIV / 2;
  // Edge (relative to the first edge seeing the start bit low) of the stop sample.
  localparam int STOP_EDGE  = 2 + HALF + 9 * DIV;
  localparam int FRAME      = 10 * DIV;

  logic clk = 1'b0;
  logic reset;
  logic uart_rx;
  int   cyc = 0;

  always #5 clk = ~clk;

  uart_receiver_if bus ();

  uart_receiver #(
    .BAUD_RATE (BAUD_RATE),
    .CLOCK_RATE(CLOCK_RATE)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .uart_rx(uart_rx),
    .rx_bus (bus)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Observation log, sampled on the falling edge.
  int         rise_cyc[$];
  logic [7:0] rise_dat[$];
  int         fe_cyc[$];
  int         ov_cyc[$];
  int         dv_cycles = 0;
  logic       dv_last = 1'b0;

  always @(negedge clk) begin
    if (bus.data_valid && !dv_last) begin
      rise_cyc.push_back(cyc);
      rise_dat.push_back(bus.data);
    end
    if (bus.data_valid) dv_cycles <= dv_cycles + 1;
    if (bus.framing_error) fe_cyc.push_back(cyc);
    if (bus.overrun) ov_cyc.push_back(cyc);
    dv_last <= bus.data_valid;
  end

  int n_assert = 0;
  int n_fail   = 0;
  int rb, fb, ob, db;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic mark();
    rb = rise_cyc.size();
    fb = fe_cyc.size();
    ob = ov_cyc.size();
    db = dv_cycles;
  endtask

  // Model: a frame whose start bit is driven when cyc==t0 yields the sent
  // byte with data_valid first seen at cyc t0+1+STOP_EDGE.
  task automatic expect_rise(input string tag, input int k, input logic [7:0] b, input int t0);
    if (rise_cyc.size() > rb + k) begin
      chk({tag, "_data"}, 32'(rise_dat[rb+k]), 32'(b));
      chk({tag, "_cyc"}, rise_cyc[rb+k], t0 + 1 + STOP_EDGE);
    end else begin
      chk({tag, "_missing"}, rise_cyc.size(), rb + k + 1);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, output int t0);
    t0 = cyc;
    uart_rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (DIV) @(negedge clk);
    end
    uart_rx = stop_bit;
    repeat (DIV) @(negedge clk);
  endtask

  task automatic idle(input int n);
    uart_rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ta, tb, tc, tdummy;
    logic [7:0] rb0, rb1, ib;
    logic [7:0] exp_b[8];
    int exp_t[8];
    int gap;

    // Reset values
    reset = 1'b1;
    uart_rx = 1'b1;
    bus.data_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_data", 32'(bus.data), 32'h00);
    chk("rst_valid", 32'(bus.data_valid), 32'h0);
    chk("rst_fe", 32'(bus.framing_error), 32'h0);
    chk("rst_ov", 32'(bus.overrun), 32'h0);
    reset = 1'b0;
    idle(20);

    // Single byte
    bus.data_ready = 1'b1;
    mark();
    send_frame(8'hA5, 1'b1, ta);
    idle(20);
    chk("a5_rises", rise_cyc.size() - rb, 1);
    expect_rise("a5", 0, 8'hA5, ta);
    chk("a5_valid_cycles", dv_cycles - db, 1);
    chk("a5_fe", fe_cyc.size() - fb, 0);
    chk("a5_ov", ov_cyc.size() - ob, 0);

    // Back-to-back frames
    mark();
    send_frame(8'h00, 1'b1, ta);
    send_frame(8'hFF, 1'b1, tb);
    send_frame(8'h55, 1'b1, tc);
    idle(20);
    chk("b2b_rises", rise_cyc.size() - rb, 3);
    expect_rise("b2b0", 0, 8'h00, ta);
    expect_rise("b2b1", 1, 8'hFF, tb);
    expect_rise("b2b2", 2, 8'h55, tc);
    if (rise_cyc.size() >= rb + 3)
      chk("b2b_spacing", rise_cyc[rb+2] - rise_cyc[rb+1], FRAME);
    chk("b2b_flags", (fe_cyc.size() - fb) + (ov_cyc.size() - ob), 0);

    // Framing error, held-low line, then a good frame
    mark();
    send_frame(8'h3C, 1'b0, ta);
    repeat (50) @(negedge clk);
    idle(DIV);
    send_frame(8'h81, 1'b1, tb);
    idle(20);
    chk("fe_pulses", fe_cyc.size() - fb, 1);
    if (fe_cyc.size() > fb) chk("fe_cyc", fe_cyc[fb], ta + 1 + STOP_EDGE);
    chk("fe_rises", rise_cyc.size() - rb, 1);
    expect_rise("fe_next", 0, 8'h81, tb);
    chk("fe_ov", ov_cyc.size() - ob, 0);

    // Start-bit glitch
    mark();
    uart_rx = 1'b0;
    repeat (4) @(negedge clk);
    idle(30);
    chk("glitch_rises", rise_cyc.size() - rb, 0);
    chk("glitch_flags", (fe_cyc.size() - fb) + (ov_cyc.size() - ob), 0);
    mark();
    send_frame(8'h12, 1'b1, ta);
    idle(20);
    chk("glitch_next_rises", rise_cyc.size() - rb, 1);
    expect_rise("glitch_next", 0, 8'h12, ta);

    // Overrun with consumer stalled
    bus.data_ready = 1'b0;
    mark();
    send_frame(8'h11, 1'b1, ta);
    send_frame(8'h22, 1'b1, tb);
    idle(20);
    chk("ovr_rises", rise_cyc.size() - rb, 1);
    expect_rise("ovr_first", 0, 8'h11, ta);
    chk("ovr_pulses", ov_cyc.size() - ob, 1);
    if (ov_cyc.size() > ob) chk("ovr_cyc", ov_cyc[ob], tb + 1 + STOP_EDGE);
    chk("ovr_hold_data", 32'(bus.data), 32'h11);
    chk("ovr_hold_valid", 32'(bus.data_valid), 32'h1);
    chk("ovr_fe", fe_cyc.size() - fb, 0);
    bus.data_ready = 1'b1;
    @(negedge clk);
    chk("ovr_drain_valid", 32'(bus.data_valid), 32'h0);

    // Accept on the same edge a new byte completes
    rb0 = 8'($urandom);
    rb1 = 8'($urandom);
    bus.data_ready = 1'b0;
    mark();
    send_frame(rb0, 1'b1, ta);
    fork
      send_frame(rb1, 1'b1, tdummy);
      begin
        repeat (STOP_EDGE) @(negedge clk);
        bus.data_ready = 1'b1;
        @(negedge clk);
        bus.data_ready = 1'b0;
        chk("coinc_data", 32'(bus.data), 32'(rb1));
        chk("coinc_valid", 32'(bus.data_valid), 32'h1);
      end
    join
    chk("coinc_ov", ov_cyc.size() - ob, 0);
    chk("coinc_rises", rise_cyc.size() - rb, 1);
    bus.data_ready = 1'b1;
    @(negedge clk);
    chk("coinc_drain", 32'(bus.data_valid), 32'h0);

    // Reset in the middle of data bit 4 while a byte is pending
    bus.data_ready = 1'b0;
    send_frame(8'($urandom), 1'b1, ta);
    idle(4);
    chk("mid_pre_valid", 32'(bus.data_valid), 32'h1);
    ib = {4'hF, 4'($urandom)};
    mark();
    uart_rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      uart_rx = ib[i];
      repeat (DIV) @(negedge clk);
    end
    uart_rx = ib[4];
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_data", 32'(bus.data), 32'h00);
    chk("mid_rst_valid", 32'(bus.data_valid), 32'h0);
    chk("mid_rst_flags", 32'({bus.framing_error, bus.overrun}), 32'h0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    bus.data_ready = 1'b1;
    repeat (DIV - 8 + 4 * DIV + 20) @(negedge clk);
    chk("mid_tail_rises", rise_cyc.size() - rb, 0);
    chk("mid_tail_flags", (fe_cyc.size() - fb) + (ov_cyc.size() - ob), 0);
    mark();
    send_frame(8'hC3, 1'b1, ta);
    idle(20);
    chk("mid_next_rises", rise_cyc.size() - rb, 1);
    expect_rise("mid_next", 0, 8'hC3, ta);

    // Random bytes with random idle gaps
    bus.data_ready = 1'b1;
    mark();
    for (int i = 0; i < 8; i++) begin
      exp_b[i] = 8'($urandom);
      gap = int'($urandom_range(0, 20));
      send_frame(exp_b[i], 1'b1, exp_t[i]);
      idle(gap);
    end
    idle(20);
    chk("rand_rises", rise_cyc.size() - rb, 8);
    for (int i = 0; i < 8; i++) expect_rise($sformatf("rand%0d", i), i, exp_b[i], exp_t[i]);
    chk("rand_flags", (fe_cyc.size() - fb) + (ov_cyc.size() - ob), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Receive half of the board UART: an asynchronous serial line (8 data bits, no parity, 1 stop bit, LSB first, idle high) enters the clock domain here and is deserialised into bytes for the rest of the design. Every received byte is held behind a valid/ready handshake, and framing errors and overruns are flagged. It sits beside the UART transmitter, shares its BAUD_RATE/CLOCK_RATE parameterisation, and drives the command/console path.

## Interface
- BAUD_RATE, 115200: line bit rate in bits/s.
- CLOCK_RATE, 25_000_000: clk frequency in Hz.
- Derived: Div = CLOCK_RATE / BAUD_RATE (integer truncation), Half = Div / 2. Div must be at least 4.
- Counter width: $clog2(Div). All counter compares are cast to that width.

Ports:
- clk, input, 1: single clock. All logic is on its rising edge.
- reset, input, 1: asynchronous, active-high reset.
- uart_rx, input, 1: raw serial line, asynchronous to clk.
- data, output, 8: received byte. Stable while data_valid=1.
- data_valid, output, 1: a byte is available.
- data_ready, input, 1: consumer accepts the byte when data_valid & data_ready are both high on a clock edge.
- framing_error, output, 1: one-cycle pulse when a stop bit is sampled low.
- overrun, output, 1: one-cycle pulse when a good byte arrives while data_valid is still high.

## Operation
- Input synchroniser: two flops on uart_rx, both reset to 1. Only the second flop output (rx_s) is used.
- State machine states: IDLE, START, DATA, STOP, BREAK. A single baud counter cnt and a bit index idx (0..7) drive it. Both are cleared on every state entry.
- IDLE: when rx_s=0, go to START.
- START: cnt increments until cnt==Half-1 (mid start bit). At that point:
  - rx_s=0: go to DATA.
  - rx_s=1: treat as a glitch and return to IDLE. No flags are raised.
- DATA: cnt counts 0..Div-1. At cnt==Div-1, shift rx_s into the shift register MSB, right-shifting so the first bit received lands at bit 0. Increment idx and wrap cnt to 0. After idx 7 is sampled, go to STOP.
- STOP: at cnt==Div-1, sample rx_s.
  - Sample is 1 and data_valid=0: load data from the shift register, set data_valid, go to IDLE.
  - Sample is 1 and data_valid=1: keep the old data and data_valid unchanged, discard the new byte, pulse overrun, go to IDLE.
  - Sample is 0: pulse framing_error, discard the byte, go to BREAK.
- BREAK: stay until rx_s=1, then go to IDLE. This stops a held-low line (break) from re-triggering.
- Handshake: data_valid clears on the edge where data_valid & data_ready. If a new byte completes on that same edge, the new byte loads, data_valid stays 1, and no overrun is raised (the accept wins first).
- data_ready is ignored while data_valid=0.

## Timing
- Reset values:
  - State = IDLE, cnt = 0, idx = 0.
  - data = 8'h00, data_valid = 0, framing_error = 0, overrun = 0.
  - Both synchroniser flops = 1.
- Reset is asynchronous: asserting it mid-frame aborts the frame immediately. After release, reception restarts from IDLE. A frame that was in progress must not produce data_valid or any flag.
- Latency: take edge 0 as the first clk edge that samples uart_rx=0 at a start bit.
  - START is entered at edge 2.
  - Mid start bit is at edge 2+Half.
  - Data bit k is sampled at edge 2+Half+(k+1)·Div.
  - data_valid rises at edge 2+Half+9·Div. With the defaults this is edge 2063.
- Because the receiver returns to IDLE at mid stop bit, it can catch a start bit that follows immediately (back-to-back frames) with no gaps lost.
- framing_error and overrun are high for exactly one cycle, on the edge after the stop sample.
- data_valid is registered: there is no combinational path from data_ready to any output.

## Test plan
Bench parameters: CLOCK_RATE=16, BAUD_RATE=1, giving Div=16 and Half=8.
- Single byte 8'hA5 sent with ideal 16-cycle bits, data_ready=1 → data=8'hA5 and data_valid high for 1 cycle at edge 154; no flags raised.
- Back-to-back frames 8'h00, 8'hFF, 8'h55 with no idle gap, data_ready=1 → three valid pulses, spaced 160 cycles apart, with correct data each time.
- Stop bit forced to 0 for frame 8'h3C → framing_error pulses at edge 154; no data_valid. Line then held low for 50 cycles before a new frame 8'h81 → only 8'h81 is received.
- Start glitch: uart_rx low for 4 cycles, then high → no state change beyond START, no outputs. A following frame 8'h12 is received correctly.
- data_ready=0, two frames 8'h11 then 8'h22 → data stays 8'h11 with data_valid held; overrun pulses at the second stop sample. Raise data_ready → data_valid drops on the next edge.
- Reset asserted during DATA bit 4 for 3 cycles → all outputs return to reset values immediately. After release, the remainder of the interrupted frame causes no data_valid, and the next full frame 8'hC3 is received.
